// File: rtl/nibble_in_port_if.sv
// Bus bundle for the nibble input port: external push handshake, processor pop side, status.
// Carries ext_parity/par_err only when INPORT_PARITY_EN is defined.
interface nibble_in_port_if #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
);
   localparam int PTR_W = $clog2(DEPTH);

   logic              ext_valid;
   logic [DATA_W-1:0] ext_data;
   logic              ext_ready;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              clear;
   logic [PTR_W:0]    count;
   logic              full;
   logic              empty;
`ifdef INPORT_PARITY_EN
   logic              ext_parity;
   logic              par_err;
`endif

   // Producer and processor side.
   modport master (
`ifdef INPORT_PARITY_EN
      output ext_parity,
      input  par_err,
`endif
      output ext_valid, ext_data, rd_en, clear,
      input  ext_ready, rd_data, rd_valid, count, full, empty
   );

   // The port itself.
   modport slave (
`ifdef INPORT_PARITY_EN
      input  ext_parity,
      output par_err,
`endif
      input  ext_valid, ext_data, rd_en, clear,
      output ext_ready, rd_data, rd_valid, count, full, empty
   );
endinterface

// File: rtl/nibble_in_port.sv
// Input port of the 4-bit core: small show-ahead FIFO between an external producer and IN.
// Optional odd-parity check on pushed nibbles is enabled by defining INPORT_PARITY_EN.
module nibble_in_port #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic            clk,
   input  logic            reset,
   nibble_in_port_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   localparam ptr_t PTR_ONE  = ptr_t'(1);
   localparam cnt_t CNT_ONE  = cnt_t'(1);
   localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   ptr_t              wr_ptr;
   ptr_t              rd_ptr;
   cnt_t              count_q;

   logic full_w;
   logic empty_w;
   logic ready_w;
   logic do_push;
   logic do_pop;
   logic do_write;

   // Status comes from the occupancy count alone, so full and empty never alias.
   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == CNT_FULL);

   // Ready looks only at registered state plus clear/reset: a pop cannot open a slot early.
   assign ready_w = !full_w && !bus.clear && !reset;
   assign do_push = bus.ext_valid && ready_w;
   assign do_pop  = bus.rd_en && !empty_w;

`ifdef INPORT_PARITY_EN
   logic par_ok;
   logic par_err_q;

   // Odd parity: data bits plus parity bit hold an odd number of ones.
   assign par_ok   = (bus.ext_parity == ~^bus.ext_data);
   // A bad nibble still completes its handshake but is never written.
   assign do_write = do_push && par_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_err_q <= 1'b0;
      end else if (bus.clear) begin
         par_err_q <= 1'b0;
      end else if (do_push && !par_ok) begin
         par_err_q <= 1'b1;
      end
   end

   assign bus.par_err = par_err_q;
`else
   assign do_write = do_push;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (bus.clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)   rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_write, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array has no reset; rd_data is masked while empty so stale contents never leak.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= bus.ext_data;
   end

   assign bus.ext_ready = ready_w;
   assign bus.rd_valid  = !empty_w;
   assign bus.rd_data   = empty_w ? '0 : mem[rd_ptr];
   assign bus.count     = count_q;
   assign bus.full      = full_w;
   assign bus.empty     = empty_w;
endmodule
